// File: rtl/switch_debouncer.sv
// switch_debouncer: per-channel two-flop synchronizer followed by a
// two-state debounce FSM. A new level must sit at the synchronizer output
// for DB_CYCLES consecutive cycles before db_out follows it. One-cycle
// rise/fall pulses are registered alongside db_out.
module switch_debouncer #(
  parameter int N         = 2,
  parameter int DB_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] db_out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_e;

  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  state_e        state_q [N];
  state_e        state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [N-1:0]  db_d;
  logic [N-1:0]  rise_d;
  logic [N-1:0]  fall_d;
  logic [N-1:0]  accept;

  // Two-flop synchronizer; only s2 is consumed by the debounce logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  // Per-channel FSM state, counter, debounced level and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      db_out <= '0;
      rise   <= '0;
      fall   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      db_out <= db_d;
      rise   <= rise_d;
      fall   <= fall_d;
    end
  end

  // Next-state logic. The state register always mirrors (s2 != db_out) after
  // each edge: the next state is decided from s1 (the next s2) against the
  // next db_out, so a reject or a bounce right after acceptance clears the
  // counter on the very edge where the levels re-align or diverge.
  always_comb begin
    db_d   = db_out;
    rise_d = '0;
    fall_d = '0;
    accept = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = STABLE;
      cnt_d[i]   = '0;
    end
    for (int i = 0; i < N; i++) begin
      accept[i] = (state_q[i] == PENDING) && (s2[i] != db_out[i]) &&
                  (cnt_q[i] == CNT_MAX);
      if (accept[i]) begin
        db_d[i]   = s2[i];
        rise_d[i] = s2[i];
        fall_d[i] = ~s2[i];
      end
      if (s1[i] != db_d[i]) begin
        state_d[i] = PENDING;
        if ((state_q[i] == PENDING) && !accept[i]) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with N=2, DB_CYCLES=4. Expected edge
// pulses are queued when a stimulus step is driven and matched against the
// DUT whenever it raises rise or fall.
module tb_switch_debouncer;

  localparam int N   = 2;
  localparam int DBC = 4;
  localparam int LAT = DBC + 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sw_in;
  logic [N-1:0] db_out;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  typedef struct {
    int         cyc;
    logic [1:0] db;
    logic [1:0] rs;
    logic [1:0] fl;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  switch_debouncer #(
    .N        (N),
    .DB_CYCLES(DBC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_in (sw_in),
    .db_out(db_out),
    .rise  (rise),
    .fall  (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int at, input logic [1:0] d, input logic [1:0] r,
                         input logic [1:0] f);
    exp_t e;
    e.cyc = at;
    e.db  = d;
    e.rs  = r;
    e.fl  = f;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and match any pulse against the queue.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst_n && ((rise | fall) != 2'b00)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {28'd0, rise, fall}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_db", {30'd0, db_out}, {30'd0, e.db});
        chk("pulse_rise", {30'd0, rise}, {30'd0, e.rs});
        chk("pulse_fall", {30'd0, fall}, {30'd0, e.fl});
      end
    end
    if ((sb.size() > 0) && (cyc > sb[0].cyc)) begin
      e = sb.pop_front();
      chk("missing_pulse", cyc, e.cyc);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // Reset held with switches already high
    rst_n = 1'b0;
    sw_in = 2'b11;
    #1;
    chk("rst_db_async", {30'd0, db_out}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_db", {30'd0, db_out}, 32'd0);
      chk("rst_rise", {30'd0, rise}, 32'd0);
      chk("rst_fall", {30'd0, fall}, 32'd0);
    end
    rst_n = 1'b1;
    sb_push(cyc + LAT, 2'b11, 2'b11, 2'b00);
    run(8);
    chk("post_rst_db", {30'd0, db_out}, 32'd3);

    // Return both channels low
    sw_in = 2'b00;
    sb_push(cyc + LAT, 2'b00, 2'b00, 2'b11);
    run(8);
    chk("both_low_db", {30'd0, db_out}, 32'd0);

    // Clean press and release on channel 0
    sw_in = 2'b01;
    sb_push(cyc + LAT, 2'b01, 2'b01, 2'b00);
    run(20);
    chk("press_db", {30'd0, db_out}, 32'd1);
    sw_in = 2'b00;
    sb_push(cyc + LAT, 2'b00, 2'b00, 2'b01);
    run(8);
    chk("release_db", {30'd0, db_out}, 32'd0);

    // Glitches on channel 1 shorter than DB_CYCLES
    sw_in = 2'b10;
    run(3);
    sw_in = 2'b00;
    run(2);
    sw_in = 2'b10;
    run(3);
    sw_in = 2'b00;
    run(8);
    chk("glitch_db", {30'd0, db_out}, 32'd0);

    // Exactly DB_CYCLES samples high is accepted, then it falls back
    sw_in = 2'b10;
    sb_push(cyc + LAT, 2'b10, 2'b10, 2'b00);
    run(4);
    sw_in = 2'b00;
    sb_push(cyc + LAT, 2'b00, 2'b00, 2'b10);
    run(8);
    chk("exact_db", {30'd0, db_out}, 32'd0);

    // Both channels change on the same cycle
    sw_in = 2'b11;
    sb_push(cyc + LAT, 2'b11, 2'b11, 2'b00);
    run(8);
    sw_in = 2'b00;
    sb_push(cyc + LAT, 2'b00, 2'b00, 2'b11);
    run(8);

    // Reset in the middle of a channel 0 count while channel 1 is high
    sw_in = 2'b10;
    sb_push(cyc + LAT, 2'b10, 2'b10, 2'b00);
    run(8);
    chk("pre_midrst_db", {30'd0, db_out}, 32'd2);
    sw_in = 2'b11;
    run(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_db_async", {30'd0, db_out}, 32'd0);
    chk("midrst_rise_async", {30'd0, rise}, 32'd0);
    run(2);
    rst_n = 1'b1;
    sb_push(cyc + LAT, 2'b11, 2'b11, 2'b00);
    run(10);
    chk("midrst_final_db", {30'd0, db_out}, 32'd3);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
